// File: rtl/systolic_seq_ctrl_if.sv
// Bundle between the operand register file, the systolic sequencer and systolic_array.
// master = register file / array side, slave = sequencer.
interface systolic_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 2
);
  localparam int DIM_W = $clog2(MAX_DIM) + 1;

  logic                                    start;
  logic [DIM_W-1:0]                        dim;
  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   mat_a;
  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   mat_b;
  logic                                    arr_reset;
  logic [MAX_DIM*DATA_WIDTH-1:0]           arr_a;
  logic [MAX_DIM*DATA_WIDTH-1:0]           arr_b;
  logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] arr_result;
  logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] mat_c;
  logic                                    busy;
  logic                                    done;
  logic                                    err;

  modport master (
    output start, dim, mat_a, mat_b, arr_result,
    input  arr_reset, arr_a, arr_b, mat_c, busy, done, err
  );

  modport slave (
    input  start, dim, mat_a, mat_b, arr_result,
    output arr_reset, arr_a, arr_b, mat_c, busy, done, err
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for systolic_array: latch operands, clear array, feed skewed wavefronts, drain, capture C.
// done follows the accepting edge by 3*MAX_DIM edges; start is ignored while busy, bad dim pulses err.
module systolic_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 2
) (
  input logic                clk,
  input logic                reset,
  systolic_seq_ctrl_if.slave bus
);
  localparam int DIM_W  = $clog2(MAX_DIM) + 1;
  localparam int STEP_W = $clog2(2 * MAX_DIM);
  localparam int MAT_W  = MAX_DIM * MAX_DIM * DATA_WIDTH;
  localparam int RES_W  = MAX_DIM * MAX_DIM * 2 * DATA_WIDTH;

  localparam logic [DIM_W-1:0]  MAX_DIM_V  = DIM_W'(MAX_DIM);
  localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(2 * MAX_DIM - 2);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(MAX_DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [MAT_W-1:0]    a_q, b_q;
  logic [DIM_W-1:0]    dim_q;
  logic [RES_W-1:0]    mat_c_q;
  logic                err_q;
  logic                dim_ok;
  logic                accept;

  assign dim_ok = (bus.dim != '0) && (bus.dim <= MAX_DIM_V);
  assign accept = (state_q == IDLE) && bus.start && dim_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dim_q   <= '0;
      mat_c_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= (state_q == IDLE) && bus.start && !dim_ok;
      if (accept) begin
        a_q   <= bus.mat_a;
        b_q   <= bus.mat_b;
        dim_q <= bus.dim;
      end
      if ((state_q == DRAIN) && (step_q == DRAIN_LAST)) begin
        mat_c_q <= bus.arr_result;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Lane i carries element k = step - i, so row i / column j enter i / j cycles late.
  always_comb begin
    int ka;
    int kb;
    ka        = 0;
    kb        = 0;
    bus.arr_a = '0;
    bus.arr_b = '0;
    if (state_q == FEED) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        ka = int'(step_q) - i;
        if ((ka >= 0) && (ka < int'(dim_q)) && (i < int'(dim_q))) begin
          bus.arr_a[i*DATA_WIDTH +: DATA_WIDTH] = a_q[(i*MAX_DIM + ka)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int j = 0; j < MAX_DIM; j++) begin
        kb = int'(step_q) - j;
        if ((kb >= 0) && (kb < int'(dim_q)) && (j < int'(dim_q))) begin
          bus.arr_b[j*DATA_WIDTH +: DATA_WIDTH] = b_q[(kb*MAX_DIM + j)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign bus.arr_reset = reset | (state_q == CLEAR);
  assign bus.mat_c     = mat_c_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl (MAX_DIM=2, DATA_WIDTH=8) with a behavioural output-stationary array attached.
module tb_systolic_seq_ctrl;
  localparam int DW = 8;
  localparam int MD = 2;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.DATA_WIDTH(DW), .MAX_DIM(MD)) bus ();

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Array model: a moves right, b moves down, each PE accumulates a*b.
  logic [2*DW-1:0] acc [MD][MD];
  logic [DW-1:0]   ar  [MD][MD];
  logic [DW-1:0]   br  [MD][MD];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return bus.arr_a[i*DW +: DW];
    else        return ar[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    if (i == 0) return bus.arr_b[j*DW +: DW];
    else        return br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        if (bus.arr_reset) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
          ar[i][j]  <= a_in(i, j);
          br[i][j]  <= b_in(i, j);
        end
      end
    end
  end

  always_comb begin
    bus.arr_result = '0;
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        bus.arr_result[(i*MD + j)*2*DW +: 2*DW] = acc[i][j];
      end
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m2(input int a00, input int a01, input int a10, input int a11);
    return {a11[7:0], a10[7:0], a01[7:0], a00[7:0]};
  endfunction

  function automatic logic [63:0] c2(input int c00, input int c01, input int c10, input int c11);
    return {c11[15:0], c10[15:0], c01[15:0], c00[15:0]};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  dim;
    logic        exp_err;
    logic [63:0] exp_c;
  } vec_t;

  vec_t tv [NV];

  logic [31:0] A1, B1, IDM;
  logic [63:0] C1;
  int          cyc;
  int          d0;

  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    A1  = m2(1, 2, 3, 4);
    B1  = m2(5, 6, 7, 8);
    IDM = m2(1, 0, 0, 1);
    C1  = c2(19, 22, 43, 50);

    tv[0] = '{A1, B1, 2'd2, 1'b0, C1};
    tv[1] = '{A1, B1, 2'd1, 1'b0, c2(5, 0, 0, 0)};
    tv[2] = '{IDM, IDM, 2'd0, 1'b1, c2(5, 0, 0, 0)};
    tv[3] = '{IDM, IDM, 2'd3, 1'b1, c2(5, 0, 0, 0)};
    tv[4] = '{m2(2, 0, 0, 3), m2(4, 1, 1, 5), 2'd2, 1'b0, c2(8, 2, 3, 15)};
    tv[5] = '{m2(255, 0, 0, 0), m2(255, 0, 0, 0), 2'd2, 1'b0, c2(65025, 0, 0, 0)};

    bus.start = 1'b0;
    bus.dim   = '0;
    bus.mat_a = '0;
    bus.mat_b = '0;
    reset     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mat_c", bus.mat_c, 0);
    chk("rst_arr_a", bus.arr_a, 0);
    chk("rst_arr_b", bus.arr_b, 0);
    chk("rst_arr_reset", bus.arr_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_arr_reset", bus.arr_reset, 0);

    // Wavefront sequence; operand inputs are scrambled after acceptance.
    bus.mat_a = A1; bus.mat_b = B1; bus.dim = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mat_a = '1; bus.mat_b = '1; bus.dim = 2'd1;
    chk("clear_arr_reset", bus.arr_reset, 1);
    chk("clear_busy", bus.busy, 1);
    chk("clear_arr_a", bus.arr_a, 0);
    @(negedge clk);
    chk("feed0_arr_a", bus.arr_a, 16'h0001);
    chk("feed0_arr_b", bus.arr_b, 16'h0005);
    chk("feed0_arr_reset", bus.arr_reset, 0);
    @(negedge clk);
    chk("feed1_arr_a", bus.arr_a, 16'h0302);
    chk("feed1_arr_b", bus.arr_b, 16'h0607);
    @(negedge clk);
    chk("feed2_arr_a", bus.arr_a, 16'h0400);
    chk("feed2_arr_b", bus.arr_b, 16'h0800);
    @(negedge clk);
    chk("drain_arr_a", bus.arr_a, 0);
    chk("drain_arr_b", bus.arr_b, 0);
    @(negedge clk);
    chk("drain1_done", bus.done, 0);
    @(negedge clk);
    chk("seq_done", bus.done, 1);
    chk("seq_busy_done", bus.busy, 1);
    chk("seq_mat_c", bus.mat_c, C1);
    @(negedge clk);
    chk("seq_idle_busy", bus.busy, 0);

    for (int v = 0; v < NV; v++) begin
      bus.mat_a = tv[v].a; bus.mat_b = tv[v].b; bus.dim = tv[v].dim; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (tv[v].exp_err) begin
        chk($sformatf("v%0d_err", v), bus.err, 1);
        chk($sformatf("v%0d_busy", v), bus.busy, 0);
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", v), bus.err, 0);
        chk($sformatf("v%0d_busy_after", v), bus.busy, 0);
        chk($sformatf("v%0d_mat_c_held", v), bus.mat_c, tv[v].exp_c);
      end else begin
        chk($sformatf("v%0d_no_err", v), bus.err, 0);
        wait_done(cyc);
        chk($sformatf("v%0d_latency", v), cyc, 7);
        chk($sformatf("v%0d_mat_c", v), bus.mat_c, tv[v].exp_c);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", v), bus.done, 0);
        chk($sformatf("v%0d_busy_after", v), bus.busy, 0);
      end
      @(negedge clk);
    end

    // Start re-asserted during FEED and DONE must be ignored.
    d0 = done_cnt;
    bus.mat_a = A1; bus.mat_b = B1; bus.dim = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.mat_a = IDM; bus.mat_b = IDM; bus.dim = 2'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_done", bus.done, 1);
    chk("ign_mat_c", bus.mat_c, C1);
    bus.dim = 2'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_err_done", bus.err, 0);
    chk("ign_busy", bus.busy, 0);
    @(negedge clk);
    chk("ign_busy2", bus.busy, 0);
    chk("ign_err2", bus.err, 0);
    chk("ign_done_count", done_cnt - d0, 1);

    // Reset during FEED step 1.
    bus.mat_a = m2(2, 0, 0, 3); bus.mat_b = m2(4, 1, 1, 5); bus.dim = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_feed_busy", bus.busy, 1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid_rst_arr_reset", bus.arr_reset, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mat_c", bus.mat_c, 0);
    chk("mid_rst_arr_a", bus.arr_a, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle", bus.busy, 0);
    bus.mat_a = A1; bus.mat_b = B1; bus.dim = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("rerun_latency", cyc, 7);
    chk("rerun_mat_c", bus.mat_c, C1);

    // Back-to-back: next start the cycle after done.
    @(negedge clk);
    bus.mat_a = IDM; bus.mat_b = IDM; bus.dim = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_accept", bus.busy, 1);
    repeat (4) @(negedge clk);
    chk("b2b_held", bus.mat_c, C1);
    cyc = 5;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_latency", cyc, 7);
    chk("b2b_mat_c", bus.mat_c, c2(1, 0, 0, 1));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
